accumulator_unit: RTL and testbench

Accumulator (AC) and carry/extend flip-flop (E) of the Mano machine datapath. The block sits directly downstream of `FastAdder`: it instantiates one `FastAdder` of width `BITS` and registers its sum and carry into AC and E. It executes register-reference and memory-operand ALU operations under a valid/ready handshake from the control sequencer, and exports AC, E and condition flags for skip instructions.

---
 rtl/accumulator_unit.sv | 178 +++++++++++++++++
 tb/tb_accumulator_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/accumulator_unit.sv
// Mano machine AC/E datapath: registers the output of a FastAdder into AC and E under a valid/ready handshake.
// Optional signed-overflow flag register enabled by defining ACCUMULATOR_OVERFLOW_EN.

module FastAdder #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    input  logic            c_in,
    output logic [BITS-1:0] sum_out,
    output logic            gg_out,
    output logic            pg_out
);
    logic [BITS-1:0] g;
    logic [BITS-1:0] p;
    logic [BITS-1:0] c;
    logic [BITS:0]   gc;

    assign c[0]  = c_in;
    assign gc[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_bit
            assign g[gi]       = a_in[gi] & b_in[gi];
            assign p[gi]       = a_in[gi] ^ b_in[gi];
            assign sum_out[gi] = p[gi] ^ c[gi];
            // Group generate is the carry chain evaluated with a zero carry-in.
            assign gc[gi+1]    = g[gi] | (p[gi] & gc[gi]);
        end
        for (gi = 1; gi < BITS; gi++) begin : g_carry
            assign c[gi] = g[gi-1] | (p[gi-1] & c[gi-1]);
        end
    endgenerate

    assign gg_out = gc[BITS];
    assign pg_out = &p;
endmodule

module accumulator_unit #(
    parameter int BITS = 16
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic [3:0]      op_in,
    input  logic            op_valid_in,
    output logic            op_ready_out,
    input  logic [BITS-1:0] data_in,
    output logic [BITS-1:0] ac_out,
    output logic            e_out,
    output logic            zero_out,
    output logic            sign_out,
    output logic            done_out,
    output logic            overflow_out
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    localparam logic [3:0] OP_CLA = 4'd1;
    localparam logic [3:0] OP_CLE = 4'd2;
    localparam logic [3:0] OP_CMA = 4'd3;
    localparam logic [3:0] OP_CME = 4'd4;
    localparam logic [3:0] OP_CIR = 4'd5;
    localparam logic [3:0] OP_CIL = 4'd6;
    localparam logic [3:0] OP_INC = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_ADD = 4'd9;
    localparam logic [3:0] OP_LDA = 4'd10;

    logic [BITS-1:0] ac_reg;
    logic            e_reg;
    logic [BITS-1:0] dr_reg;
    logic [3:0]      op_reg;
    logic [0:0]      state_reg;
    logic            done_reg;

    logic [BITS-1:0] add_b;
    logic            add_cin;
    logic [BITS-1:0] add_sum;
    logic            add_gg;
    logic            add_pg;
    logic            add_cout;

    // In EXEC the adder serves ADD (b=DR, cin=0); in IDLE it serves INC (b=0, cin=1).
    assign add_b   = (state_reg == ST_EXEC) ? dr_reg : '0;
    assign add_cin = (state_reg == ST_IDLE);

    FastAdder #(.BITS(BITS)) u_adder (
        .a_in    (ac_reg),
        .b_in    (add_b),
        .c_in    (add_cin),
        .sum_out (add_sum),
        .gg_out  (add_gg),
        .pg_out  (add_pg)
    );

    assign add_cout = add_gg | (add_pg & add_cin);

    logic accept;
    assign accept = op_valid_in && (state_reg == ST_IDLE);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ac_reg    <= '0;
            e_reg     <= 1'b0;
            dr_reg    <= '0;
            op_reg    <= 4'd0;
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == ST_EXEC) begin
                case (op_reg)
                    OP_AND: ac_reg <= ac_reg & dr_reg;
                    OP_ADD: begin
                        ac_reg <= add_sum;
                        e_reg  <= add_cout;
                    end
                    OP_LDA: ac_reg <= dr_reg;
                    default: ;
                endcase
                done_reg  <= 1'b1;
                state_reg <= ST_IDLE;
            end else if (accept) begin
                case (op_in)
                    OP_CLA: begin ac_reg <= '0;      done_reg <= 1'b1; end
                    OP_CLE: begin e_reg  <= 1'b0;    done_reg <= 1'b1; end
                    OP_CMA: begin ac_reg <= ~ac_reg; done_reg <= 1'b1; end
                    OP_CME: begin e_reg  <= ~e_reg;  done_reg <= 1'b1; end
                    OP_CIR: begin
                        ac_reg   <= {e_reg, ac_reg[BITS-1:1]};
                        e_reg    <= ac_reg[0];
                        done_reg <= 1'b1;
                    end
                    OP_CIL: begin
                        ac_reg   <= {ac_reg[BITS-2:0], e_reg};
                        e_reg    <= ac_reg[BITS-1];
                        done_reg <= 1'b1;
                    end
                    OP_INC: begin ac_reg <= add_sum; done_reg <= 1'b1; end
                    OP_AND, OP_ADD, OP_LDA: begin
                        dr_reg    <= data_in;
                        op_reg    <= op_in;
                        state_reg <= ST_EXEC;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ACCUMULATOR_OVERFLOW_EN
    logic ov_reg;
    logic ov_next;

    // For INC the effective second operand is +1, whose sign bit is add_b's (zero).
    assign ov_next = (ac_reg[BITS-1] == add_b[BITS-1]) && (add_sum[BITS-1] != ac_reg[BITS-1]);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ov_reg <= 1'b0;
        end else if ((state_reg == ST_EXEC && op_reg == OP_ADD) || (accept && op_in == OP_INC)) begin
            ov_reg <= ov_next;
        end
    end

    assign overflow_out = ov_reg;
`else
    assign overflow_out = 1'b0;
`endif

    assign op_ready_out = (state_reg == ST_IDLE);
    assign ac_out       = ac_reg;
    assign e_out        = e_reg;
    assign zero_out     = (ac_reg == '0);
    assign sign_out     = ac_reg[BITS-1];
    assign done_out     = done_reg;
endmodule

// File: tb/tb_accumulator_unit.sv
// Bench for accumulator_unit: directed scenarios then randomized operations checked against an arithmetic reference model.
module tb_accumulator_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  op = 4'd0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] data = 16'd0;
    logic [15:0] ac;
    logic        e;
    logic        zero;
    logic        sign;
    logic        done;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_ac, m_e, m_dr, m_op, m_busy, m_done, m_ov;

    accumulator_unit #(.BITS(16)) dut (
        .clk_in       (clk),
        .reset_in     (rst),
        .op_in        (op),
        .op_valid_in  (op_valid),
        .op_ready_out (op_ready),
        .data_in      (data),
        .ac_out       (ac),
        .e_out        (e),
        .zero_out     (zero),
        .sign_out     (sign),
        .done_out     (done),
        .overflow_out (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    task automatic model_reset();
        m_ac = 0; m_e = 0; m_dr = 0; m_op = 0; m_busy = 0; m_done = 0; m_ov = 0;
    endtask

    task automatic model_edge(input logic v, input int opc, input int d);
        int s;
        m_done = 0;
        if (m_busy != 0) begin
            case (m_op)
                8:  m_ac = m_ac & m_dr;
                9: begin
                    s = to_signed16(m_ac) + to_signed16(m_dr);
                    m_ov = (s > 32767 || s < -32768) ? 1 : 0;
                    s = m_ac + m_dr;
                    m_e = s / 65536;
                    m_ac = s % 65536;
                end
                default: m_ac = m_dr;
            endcase
            m_done = 1;
            m_busy = 0;
        end else if (v) begin
            case (opc)
                1: begin m_ac = 0; m_done = 1; end
                2: begin m_e = 0; m_done = 1; end
                3: begin m_ac = 65535 - m_ac; m_done = 1; end
                4: begin m_e = 1 - m_e; m_done = 1; end
                5: begin s = m_ac % 2; m_ac = m_e * 32768 + m_ac / 2; m_e = s; m_done = 1; end
                6: begin s = m_ac / 32768; m_ac = (m_ac * 2) % 65536 + m_e; m_e = s; m_done = 1; end
                7: begin m_ov = (m_ac == 32767) ? 1 : 0; m_ac = (m_ac + 1) % 65536; m_done = 1; end
                8, 9, 10: begin m_dr = d; m_op = opc; m_busy = 1; end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ac"}, 32'(ac), 32'(m_ac));
        check({tag, ".e"}, 32'(e), 32'(m_e));
        check({tag, ".zero"}, 32'(zero), (m_ac == 0) ? 32'd1 : 32'd0);
        check({tag, ".sign"}, 32'(sign), 32'(m_ac / 32768));
        check({tag, ".ready"}, 32'(op_ready), (m_busy == 0) ? 32'd1 : 32'd0);
        check({tag, ".done"}, 32'(done), 32'(m_done));
`ifdef ACCUMULATOR_OVERFLOW_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ov));
`else
        check({tag, ".ovf"}, 32'(ovf), 32'd0);
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] opc, input logic [15:0] d);
        @(negedge clk);
        op_valid = v;
        op = opc;
        data = d;
        model_edge(v, int'(opc), int'(d));
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Asserts reset between edges and checks that state clears without any clock edge.
    task automatic mid_cycle_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs({tag, ".held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic        v;
        logic [3:0]  opc;
        logic [15:0] d;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("reset");

        // Overflow into sign bit
        step("lda7fff", 1'b1, 4'd10, 16'h7FFF);
        step("lda7fff.x", 1'b0, 4'd0, 16'h0000);
        step("add1", 1'b1, 4'd9, 16'h0001);
        step("add1.x", 1'b0, 4'd0, 16'h0000);
        step("idle", 1'b0, 4'd0, 16'h0000);
        // Carry into E, then INC leaves E alone
        step("lda1", 1'b1, 4'd10, 16'h0001);
        step("lda1.x", 1'b0, 4'd0, 16'h0000);
        step("addffff", 1'b1, 4'd9, 16'hFFFF);
        step("addffff.x", 1'b0, 4'd0, 16'h0000);
        step("inc", 1'b1, 4'd7, 16'h0000);
        // Rotates and complements back-to-back
        step("lda8001", 1'b1, 4'd10, 16'h8001);
        step("lda8001.x", 1'b0, 4'd0, 16'h0000);
        step("cle", 1'b1, 4'd2, 16'h0000);
        step("cil", 1'b1, 4'd6, 16'h0000);
        step("cir", 1'b1, 4'd5, 16'h0000);
        step("cma", 1'b1, 4'd3, 16'h0000);
        step("cme", 1'b1, 4'd4, 16'h0000);
        step("and00f0", 1'b1, 4'd8, 16'h00F0);
        step("and00f0.x", 1'b0, 4'd0, 16'h0000);
        check("and_result", 32'(ac), 32'h00F0);
        // CLA held valid during EXEC must wait
        step("lda2", 1'b1, 4'd10, 16'h0002);
        step("lda2.x", 1'b0, 4'd0, 16'h0000);
        step("add3", 1'b1, 4'd9, 16'h0003);
        step("cla_blocked", 1'b1, 4'd1, 16'h0000);
        check("add3_result", 32'(ac), 32'h0005);
        step("cla_taken", 1'b1, 4'd1, 16'h0000);
        check("cla_result", 32'(ac), 32'h0000);
        // Reset during EXEC aborts the load
        step("lda1234", 1'b1, 4'd10, 16'h1234);
        mid_cycle_reset("rst_exec");
        step("post_rst", 1'b0, 4'd0, 16'h0000);
        step("op13", 1'b1, 4'd13, 16'hBEEF);
        step("op13.x", 1'b0, 4'd0, 16'h0000);

        // Randomized: the held operation is repeated while the block is busy
        v = 1'b0; opc = 4'd0; d = 16'd0;
        for (int i = 0; i < 400; i++) begin
            if (m_busy == 0) begin
                v = ($urandom_range(0, 3) != 0);
                opc = 4'($urandom_range(0, 15));
                d = 16'($urandom);
                if ($urandom_range(0, 7) == 0) d = 16'h7FFF;
            end
            step("rand", v, opc, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
